apb_fabric_n: RTL and testbench

//  Parametrised APB interconnect; next generation of the fixed 8-port amba_apb_bus. Sits between the memory-mapped APB master and N peripherals.

---
 rtl/apb_fabric_pkg.sv | 19 +
 rtl/apb_timeout_ctr.sv | 44 ++++
 rtl/apb_fabric_n.sv | 166 ++++++++++++++++
 tb/tb_apb_fabric_n.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_fabric_pkg.sv
// Shared definitions for the parametrised APB fabric: FSM state encoding,
// the value returned on error responses and default select-field geometry.
package apb_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Every bit of the read data returned with an error response
  localparam logic ERR_RDATA_BIT = 1'b0;

  // Default position and width of the slave-select field in the address
  localparam int DEF_SEL_LSB = 12;
  localparam int DEF_SEL_W   = 3;

endpackage

// File: rtl/apb_timeout_ctr.sv
// Wait-state counter for the APB fabric. It is cleared while the fabric is in
// SETUP and counts ACCESS cycles in which the selected slave is not ready.
// hit_o flags the cycle that would be the TIMEOUT_CYC-th such cycle, so the
// fabric can leave ACCESS on that same clock edge.
module apb_timeout_ctr
  import apb_fabric_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear takes priority over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = inc_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/apb_fabric_n.sv
// Parametrised APB interconnect between one master and NUM_SLAVES slaves.
// The slave is decoded from paddr[SEL_LSB +: SEL_W]; unmapped indices get an
// immediate PSLVERR response. Every transfer is registered, so no input has a
// combinational path to any output.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase with
// PSLVERR after TIMEOUT_CYC cycles without s_pready from the selected slave.
module apb_fabric_n
  import apb_fabric_pkg::*;
#(
  parameter int NUM_SLAVES  = 8,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = DEF_SEL_LSB,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_psel,
  input  logic                         m_penable,
  input  logic                         m_pwrite,
  input  logic [ADDR_W-1:0]            m_paddr,
  input  logic [DATA_W-1:0]            m_pwdata,
  output logic                         m_pready,
  output logic [DATA_W-1:0]            m_prdata,
  output logic                         m_pslverr,
  output logic [NUM_SLAVES-1:0]        s_psel,
  output logic                         s_penable,
  output logic                         s_pwrite,
  output logic [ADDR_W-1:0]            s_paddr,
  output logic [DATA_W-1:0]            s_pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]        s_pready,
  input  logic [NUM_SLAVES-1:0]        s_pslverr
);

  localparam logic [SEL_W:0]    NUM_IDX   = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [DATA_W-1:0] ERR_RDATA = {DATA_W{ERR_RDATA_BIT}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pwrite_q, pwrite_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]      idxIn;
  logic [NUM_SLAVES-1:0] selDec;
  logic [DATA_W-1:0]     selRdata;
  logic                  selReady;
  logic                  selErr;
  logic                  timeoutHit;

  assign idxIn = m_paddr[SEL_LSB +: SEL_W];

  // Select decode and return-path mux for the latched slave index
  always_comb begin
    selDec   = '0;
    selRdata = '0;
    selReady = 1'b0;
    selErr   = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_W'(k)) begin
        selDec[k] = 1'b1;
        selRdata  = s_prdata[k*DATA_W +: DATA_W];
        selReady  = s_pready[k];
        selErr    = s_pslverr[k];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  apb_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_SETUP),
    .inc_i ((state_q == ST_ACCESS) && !selReady),
    .hit_o (timeoutHit)
  );
`else
  assign timeoutHit = 1'b0;
`endif

  // Transfer FSM next state plus the latched request and response values
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pwrite_d = pwrite_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m_psel && !m_penable) begin
          addr_d   = m_paddr;
          wdata_d  = m_pwdata;
          pwrite_d = m_pwrite;
          idx_d    = idxIn;
          err_d    = 1'b0;
          if ({1'b0, idxIn} < NUM_IDX) begin
            state_d = ST_SETUP;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (selReady) begin
          rdata_d = pwrite_q ? ERR_RDATA : selRdata;
          err_d   = selErr;
          state_d = ST_RESP;
        end else if (timeoutHit) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers; reset clears everything, abandoning any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      pwrite_q <= 1'b0;
      idx_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      pwrite_q <= pwrite_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign s_psel    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? selDec : '0;
  assign s_penable = (state_q == ST_ACCESS);
  assign s_pwrite  = pwrite_q;
  assign s_paddr   = addr_q;
  assign s_pwdata  = wdata_q;
  assign m_pready  = (state_q == ST_RESP);
  assign m_pslverr = (state_q == ST_RESP) && err_q;
  assign m_prdata  = rdata_q;

endmodule

// File: tb/tb_apb_fabric_n.sv
// Directed testbench for apb_fabric_n: an 8-slave instance for the main
// transfers plus a 4-slave instance for unmapped-address responses.
// Covers both builds of the APB_TIMEOUT_EN option.
module tb_apb_fabric_n;

  localparam int NS = 8;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  logic           mPsel, mPenable, mPwrite;
  logic [AW-1:0]  mPaddr;
  logic [DW-1:0]  mPwdata;
  logic           mPready;
  logic [DW-1:0]  mPrdata;
  logic           mPslverr;
  logic [NS-1:0]  sPsel;
  logic           sPenable, sPwrite;
  logic [AW-1:0]  sPaddr;
  logic [DW-1:0]  sPwdata;
  logic [NS*DW-1:0] sPrdata;
  logic [NS-1:0]  sPready, sPslverr;

  logic           mPsel4;
  logic           mPready4;
  logic [DW-1:0]  mPrdata4;
  logic           mPslverr4;
  logic [3:0]     sPsel4;
  logic           sPenable4, sPwrite4;
  logic [AW-1:0]  sPaddr4;
  logic [DW-1:0]  sPwdata4;
  logic [4*DW-1:0] sPrdata4 = {4{32'hA5A5A5A5}};
  logic [3:0]     sPready4  = 4'hF;
  logic [3:0]     sPslverr4 = 4'h0;

  int testsRun    = 0;
  int testsFailed = 0;

  apb_fabric_n #(.NUM_SLAVES(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_psel    (mPsel),
    .m_penable (mPenable),
    .m_pwrite  (mPwrite),
    .m_paddr   (mPaddr),
    .m_pwdata  (mPwdata),
    .m_pready  (mPready),
    .m_prdata  (mPrdata),
    .m_pslverr (mPslverr),
    .s_psel    (sPsel),
    .s_penable (sPenable),
    .s_pwrite  (sPwrite),
    .s_paddr   (sPaddr),
    .s_pwdata  (sPwdata),
    .s_prdata  (sPrdata),
    .s_pready  (sPready),
    .s_pslverr (sPslverr)
  );

  apb_fabric_n #(.NUM_SLAVES(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .m_psel    (mPsel4),
    .m_penable (mPenable),
    .m_pwrite  (mPwrite),
    .m_paddr   (mPaddr),
    .m_pwdata  (mPwdata),
    .m_pready  (mPready4),
    .m_prdata  (mPrdata4),
    .m_pslverr (mPslverr4),
    .s_psel    (sPsel4),
    .s_penable (sPenable4),
    .s_pwrite  (sPwrite4),
    .s_paddr   (sPaddr4),
    .s_pwdata  (sPwdata4),
    .s_prdata  (sPrdata4),
    .s_pready  (sPready4),
    .s_pslverr (sPslverr4)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic wr,
                               input logic [DW-1:0] wdata);
    mPsel    = 1'b1;
    mPenable = 1'b0;
    mPwrite  = wr;
    mPaddr   = addr;
    mPwdata  = wdata;
  endtask

  task automatic setSlave(input int k, input logic [DW-1:0] d);
    sPrdata[k*DW +: DW] = d;
  endtask

  // Full master transfer; returns in the cycle where RESP is expected
  task automatic runXfer(input logic [AW-1:0] addr, input logic wr,
                         input logic [DW-1:0] wdata, input int waits,
                         input logic [NS-1:0] readyMask);
    applyStimulus(addr, wr, wdata);
    tick;
    mPenable = 1'b1;
    tick;
    repeat (waits) tick;
    sPready = readyMask;
    tick;
    sPready  = '0;
    mPsel    = 1'b0;
    mPenable = 1'b0;
  endtask

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int  waited;
    logic stuckBroken;
    mPsel = 1'b0; mPenable = 1'b0; mPwrite = 1'b0; mPaddr = '0; mPwdata = '0;
    mPsel4 = 1'b0;
    sPrdata = '0; sPready = '0; sPslverr = '0;
    rst = 1'b1;
    tick;
    tick;
    checkOutput("rst_s_psel", sPsel, 0);
    checkOutput("rst_s_penable", sPenable, 0);
    checkOutput("rst_s_pwrite", sPwrite, 0);
    checkOutput("rst_s_paddr", sPaddr, 0);
    checkOutput("rst_m_pready", mPready, 0);
    checkOutput("rst_m_prdata", mPrdata, 0);
    checkOutput("rst_m_pslverr", mPslverr, 0);
    rst = 1'b0;
    tick;

    // Read from slave 2, zero wait states
    setSlave(2, 32'hDEADBEEF);
    applyStimulus(32'h0000_2010, 1'b0, '0);
    tick;
    checkOutput("t1_psel_T1", sPsel, 8'h04);
    checkOutput("t1_penable_T1", sPenable, 0);
    checkOutput("t1_pready_T1", mPready, 0);
    mPenable = 1'b1;
    tick;
    checkOutput("t1_penable_T2", sPenable, 1);
    checkOutput("t1_paddr_T2", sPaddr, 32'h0000_2010);
    checkOutput("t1_pready_T2", mPready, 0);
    sPready = 8'h04;
    tick;
    checkOutput("t1_pready_T3", mPready, 1);
    checkOutput("t1_prdata_T3", mPrdata, 32'hDEADBEEF);
    checkOutput("t1_pslverr_T3", mPslverr, 0);
    checkOutput("t1_psel_resp", sPsel, 0);
    sPready = '0; mPsel = 1'b0; mPenable = 1'b0;
    tick;
    checkOutput("t1_pready_T4", mPready, 0);
    checkOutput("t1_prdata_hold", mPrdata, 32'hDEADBEEF);

    // Write to slave 5 with three wait states; other slaves' ready ignored
    setSlave(5, 32'hCAFEF00D);
    applyStimulus(32'h0000_5004, 1'b1, 32'h12345678);
    tick;
    checkOutput("t2_psel_T1", sPsel, 8'h20);
    mPenable = 1'b1;
    sPready = 8'hDF;
    tick;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_psel_wait", sPsel, 8'h20);
      checkOutput("t2_penable_wait", sPenable, 1);
      checkOutput("t2_pwrite_wait", sPwrite, 1);
      checkOutput("t2_pwdata_wait", sPwdata, 32'h12345678);
      checkOutput("t2_pready_wait", mPready, 0);
      tick;
    end
    checkOutput("t2_pready_T5", mPready, 0);
    sPready = 8'h20;
    tick;
    checkOutput("t2_pready_T6", mPready, 1);
    checkOutput("t2_prdata_write", mPrdata, 0);
    checkOutput("t2_pslverr", mPslverr, 0);
    sPready = '0; mPsel = 1'b0; mPenable = 1'b0;
    tick;

    // Slave 0 error, then back-to-back clean read from slave 0
    setSlave(0, 32'h11112222);
    sPslverr = 8'h01;
    runXfer(32'h0000_0100, 1'b0, '0, 0, 8'h01);
    checkOutput("t5_err_pready", mPready, 1);
    checkOutput("t5_err_pslverr", mPslverr, 1);
    checkOutput("t5_err_prdata", mPrdata, 32'h11112222);
    sPslverr = '0;
    setSlave(0, 32'h55556666);
    tick;
    runXfer(32'h0000_0200, 1'b0, '0, 1, 8'h01);
    checkOutput("t5_ok_pready", mPready, 1);
    checkOutput("t5_ok_pslverr", mPslverr, 0);
    checkOutput("t5_ok_prdata", mPrdata, 32'h55556666);
    tick;
    checkOutput("t5_pready_after", mPready, 0);
    checkOutput("t5_pslverr_after", mPslverr, 0);

    // Reset in ACCESS aborts, then a read from slave 3 completes
    setSlave(3, 32'h33334444);
    applyStimulus(32'h0000_3008, 1'b1, 32'h9999AAAA);
    tick;
    mPenable = 1'b1;
    tick;
    checkOutput("t6_psel_access", sPsel, 8'h08);
    rst = 1'b1;
    tick;
    rst = 1'b0; mPsel = 1'b0; mPenable = 1'b0;
    checkOutput("t6_rst_psel", sPsel, 0);
    checkOutput("t6_rst_penable", sPenable, 0);
    checkOutput("t6_rst_pready", mPready, 0);
    checkOutput("t6_rst_prdata", mPrdata, 0);
    checkOutput("t6_rst_pwrite", sPwrite, 0);
    checkOutput("t6_rst_pwdata", sPwdata, 0);
    tick;
    runXfer(32'h0000_3008, 1'b0, '0, 0, 8'h08);
    checkOutput("t6_read_pready", mPready, 1);
    checkOutput("t6_read_prdata", mPrdata, 32'h33334444);
    checkOutput("t6_read_pslverr", mPslverr, 0);
    tick;

    // Four-slave instance: mapped read, then unmapped index 6
    mPaddr = 32'h0000_3000; mPwrite = 1'b0; mPenable = 1'b0; mPsel4 = 1'b1;
    tick;
    checkOutput("t3_map_psel", sPsel4, 4'h8);
    mPenable = 1'b1;
    tick;
    tick;
    checkOutput("t3_map_pready", mPready4, 1);
    checkOutput("t3_map_prdata", mPrdata4, 32'hA5A5A5A5);
    mPsel4 = 1'b0; mPenable = 1'b0;
    tick;
    mPaddr = 32'h0000_6000; mPsel4 = 1'b1;
    checkOutput("t3_unmap_psel_T0", sPsel4, 0);
    tick;
    checkOutput("t3_unmap_pready", mPready4, 1);
    checkOutput("t3_unmap_pslverr", mPslverr4, 1);
    checkOutput("t3_unmap_prdata", mPrdata4, 0);
    checkOutput("t3_unmap_psel_T1", sPsel4, 0);
    mPsel4 = 1'b0;
    tick;
    checkOutput("t3_unmap_pready_after", mPready4, 0);
    checkOutput("t3_unmap_pslverr_after", mPslverr4, 0);

    // Slave 1 never ready
    applyStimulus(32'h0000_1000, 1'b0, '0);
    tick;
    mPenable = 1'b1;
    tick;
    checkOutput("t4_psel_access", sPsel, 8'h02);
    checkOutput("t4_penable_access", sPenable, 1);
`ifdef APB_TIMEOUT_EN
    waited = 0;
    while (mPready !== 1'b1 && waited < 40) begin
      tick;
      waited++;
    end
    checkOutput("t4_timeout_cycles", waited, 16);
    checkOutput("t4_timeout_pslverr", mPslverr, 1);
    checkOutput("t4_timeout_prdata", mPrdata, 0);
    checkOutput("t4_timeout_psel", sPsel, 0);
    checkOutput("t4_timeout_penable", sPenable, 0);
    mPsel = 1'b0; mPenable = 1'b0;
    tick;
    checkOutput("t4_timeout_pready_after", mPready, 0);
`else
    stuckBroken = 1'b0;
    waited = 0;
    repeat (120) begin
      tick;
      waited++;
      if (mPready !== 1'b0 || sPsel !== 8'h02 || sPenable !== 1'b1) stuckBroken = 1'b1;
    end
    checkOutput("t4_stays_in_access", stuckBroken, 0);
    checkOutput("t4_wait_cycles", waited, 120);
    mPsel = 1'b0; mPenable = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("t4_recover_psel", sPsel, 0);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
